// File: rtl/missile_ctl.sv
// missile_ctl: player-missile controller.
// Launches a missile from the ship on a fire request, moves it up by SPEED
// pixels once per frame (rising vsync edge), retires it at the top of the
// screen or on a hit, and then holds off further launches for
// COOLDOWN_FRAMES frame ticks. All outputs come straight from flops.
//
// Handshake note: there is no valid/ready pair here. 'on' qualifies
// xpos_out/ypos_out: while on=0 the position outputs just hold their last
// value and must be ignored downstream. 'launch' is a single-cycle pulse,
// aligned with the first cycle in which on=1.
//
// state_dbg exposes the FSM state (0=IDLE, 1=FLYING, 2=COOLDOWN) for
// checkers; it is not used by the draw pipeline.

module missile_ctl #(
    parameter int SPEED           = 8,
    parameter int Y_TOP           = 0,
    parameter int MISSILE_H       = 20,
    parameter int COOLDOWN_FRAMES = 10
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        fire,
    input  logic        hit,
    input  logic [10:0] ship_xpos,
    input  logic [10:0] ship_ypos,
    output logic [10:0] xpos_out,
    output logic [10:0] ypos_out,
    output logic        on,
    output logic        launch,
    output logic [1:0]  state_dbg
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLYING   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    // Counter wide enough to hold COOLDOWN_FRAMES (at least 1 bit).
    localparam int                CNT_W    = $clog2(COOLDOWN_FRAMES + 2);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);

    // Retire threshold kept at 12 bits so Y_TOP+SPEED can never wrap.
    localparam logic [11:0] RETIRE_LIM = 12'(Y_TOP + SPEED);
    localparam logic [10:0] SPEED_V    = 11'(SPEED);
    localparam logic [10:0] HEIGHT_V   = 11'(MISSILE_H);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             vsync_dly_q,  vsync_dly_d;
    logic             fire_armed_q, fire_armed_d;
    logic [10:0]      xpos_q,       xpos_d;
    logic [10:0]      ypos_q,       ypos_d;
    logic             on_q,         on_d;
    logic             launch_q,     launch_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        tick;
    logic        do_launch;
    logic        at_top;
    logic [10:0] launch_ypos;

    // Frame tick, launch condition and launch position.
    always_comb begin
        tick        = vsync_in & ~vsync_dly_q;
        do_launch   = (state_q == ST_IDLE) & fire & fire_armed_q;
        // Retire when one more step would take the missile above Y_TOP;
        // this also guarantees the SPEED subtraction never underflows.
        at_top      = ({1'b0, ypos_q} < RETIRE_LIM);
        // Launch position sits MISSILE_H above the ship, clamped to row 0.
        if (ship_ypos < HEIGHT_V) begin
            launch_ypos = 11'd0;
        end else begin
            launch_ypos = ship_ypos - HEIGHT_V;
        end
    end

    // Edge detector delay and fire re-arming (a held button never refires).
    always_comb begin
        vsync_dly_d  = vsync_in;
        fire_armed_d = fire_armed_q;
        if (!fire) begin
            fire_armed_d = 1'b1;
        end else if (do_launch) begin
            fire_armed_d = 1'b0;
        end
    end

    // Main FSM plus missile position datapath.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        on_d     = on_q;
        launch_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                on_d = 1'b0;
                if (do_launch) begin
                    state_d  = ST_FLYING;
                    on_d     = 1'b1;
                    launch_d = 1'b1;
                    // x is captured once; the draw stage applies centring.
                    xpos_d   = ship_xpos;
                    ypos_d   = launch_ypos;
                end
            end

            ST_FLYING: begin
                // Hit wins over any movement in the same cycle.
                if (hit) begin
                    state_d = ST_COOLDOWN;
                    on_d    = 1'b0;
                    cnt_d   = CNT_LOAD;
                end else if (tick && at_top) begin
                    state_d = ST_COOLDOWN;
                    on_d    = 1'b0;
                    cnt_d   = CNT_LOAD;
                end else if (tick) begin
                    ypos_d  = ypos_q - SPEED_V;
                end
            end

            ST_COOLDOWN: begin
                on_d = 1'b0;
                // Zero test runs every cycle so COOLDOWN_FRAMES=0 costs
                // exactly one cycle in this state.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                on_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            vsync_dly_q  <= 1'b0;
            fire_armed_q <= 1'b1;
            xpos_q       <= 11'd0;
            ypos_q       <= 11'd0;
            on_q         <= 1'b0;
            launch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vsync_dly_q  <= vsync_dly_d;
            fire_armed_q <= fire_armed_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            on_q         <= on_d;
            launch_q     <= launch_d;
        end
    end

    assign xpos_out  = xpos_q;
    assign ypos_out  = ypos_q;
    assign on        = on_q;
    assign launch    = launch_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_missile_ctl.sv
// tb_missile_ctl: directed plus random stimulus for missile_ctl, checked
// every cycle against a behavioural reference model of the missile.

module tb_missile_ctl;

    localparam int SPEED     = 8;
    localparam int Y_TOP     = 0;
    localparam int MISSILE_H = 20;
    localparam int COOL      = 10;

    // Phase labels of the reference model (match the documented state_dbg).
    localparam int P_IDLE = 0;
    localparam int P_FLY  = 1;
    localparam int P_COOL = 2;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        vsync_in = 1'b0;
    logic        fire = 1'b0;
    logic        hit  = 1'b0;
    logic [10:0] ship_xpos = 11'd0;
    logic [10:0] ship_ypos = 11'd0;
    logic [10:0] xpos_out;
    logic [10:0] ypos_out;
    logic        on;
    logic        launch;
    logic [1:0]  state_dbg;

    always #5 pclk = ~pclk;

    missile_ctl #(
        .SPEED(SPEED), .Y_TOP(Y_TOP), .MISSILE_H(MISSILE_H), .COOLDOWN_FRAMES(COOL)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .fire(fire), .hit(hit),
        .ship_xpos(ship_xpos), .ship_ypos(ship_ypos),
        .xpos_out(xpos_out), .ypos_out(ypos_out), .on(on), .launch(launch),
        .state_dbg(state_dbg)
    );

    // ------------------------------------------------------------------
    // Reference model: missile position as plain integers
    // ------------------------------------------------------------------
    int m_phase, m_x, m_y, m_cool, m_on, m_launch, m_armed, m_prev_vs;
    int n_checks = 0;
    int n_fail   = 0;
    int n_launch = 0;

    task automatic model_reset();
        m_phase = P_IDLE; m_x = 0; m_y = 0; m_cool = 0;
        m_on = 0; m_launch = 0; m_armed = 1; m_prev_vs = 0;
    endtask

    // Advance the model by one clock using the inputs presented now.
    task automatic model_step();
        int  new_frame;
        new_frame = (vsync_in && !m_prev_vs) ? 1 : 0;
        m_prev_vs = int'(vsync_in);
        m_launch  = 0;
        if (m_phase == P_IDLE) begin
            if (fire && m_armed != 0) begin
                m_phase  = P_FLY;
                m_on     = 1;
                m_launch = 1;
                m_x      = int'(ship_xpos);
                m_y      = int'(ship_ypos) - MISSILE_H;
                if (m_y < 0) m_y = 0;
                m_armed  = 0;
            end
        end else if (m_phase == P_FLY) begin
            if (hit || (new_frame != 0 && m_y - SPEED < Y_TOP)) begin
                m_phase = P_COOL; m_on = 0; m_cool = COOL;
            end else if (new_frame != 0) begin
                m_y = m_y - SPEED;
            end
        end else begin
            if (m_cool == 0) m_phase = P_IDLE;
            else if (new_frame != 0) m_cool = m_cool - 1;
        end
        if (!fire) m_armed = 1;
    endtask

    // ------------------------------------------------------------------
    // Scoreboard helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("on",       {11'd0, on},       12'(m_on));
        chk("launch",   {11'd0, launch},   12'(m_launch));
        chk("xpos",     {1'b0, xpos_out},  12'(m_x));
        chk("ypos",     {1'b0, ypos_out},  12'(m_y));
        chk("state",    {10'd0, state_dbg}, 12'(m_phase));
    endtask

    // One clock: model predicts, DUT clocks, compare 1 time unit later.
    task automatic cycle();
        if (rst) model_reset();
        else model_step();
        @(posedge pclk);
        #1;
        if (launch === 1'b1) n_launch++;
        check_model();
    endtask

    task automatic frame_tick();
        vsync_in = 1'b1;
        cycle();
        vsync_in = 1'b0;
        cycle();
    endtask

    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) frame_tick();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence followed by random traffic
    // ------------------------------------------------------------------
    int launches_before;

    initial begin
        model_reset();
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        chk("reset_on",     {11'd0, on},     12'd0);
        chk("reset_launch", {11'd0, launch}, 12'd0);
        chk("reset_xpos",   {1'b0, xpos_out}, 12'd0);
        chk("reset_ypos",   {1'b0, ypos_out}, 12'd0);
        rst = 1'b0;
        cycle();

        // Launch from ship at (400,550).
        ship_xpos = 11'd400; ship_ypos = 11'd550;
        fire = 1'b1;
        cycle();
        chk("launch_on",     {11'd0, on},      12'd1);
        chk("launch_pulse",  {11'd0, launch},  12'd1);
        chk("launch_xpos",   {1'b0, xpos_out}, 12'd400);
        chk("launch_ypos",   {1'b0, ypos_out}, 12'd530);
        fire = 1'b0;
        ship_xpos = 11'd123;                 // ship moves; missile must not follow
        cycle();
        chk("launch_one_cycle", {11'd0, launch}, 12'd0);

        // Flight up to the top.
        frame_tick();
        chk("tick1_ypos", {1'b0, ypos_out}, 12'd522);
        chk("tick1_xpos_held", {1'b0, xpos_out}, 12'd400);
        frame_ticks(65);
        chk("tick66_ypos", {1'b0, ypos_out}, 12'd2);
        chk("tick66_on",   {11'd0, on},      12'd1);
        frame_tick();
        chk("tick67_on",   {11'd0, on},      12'd0);
        chk("tick67_state", {10'd0, state_dbg}, 12'd2);
        frame_ticks(9);
        chk("cool9_state", {10'd0, state_dbg}, 12'd2);
        frame_tick();
        chk("cool_done_state", {10'd0, state_dbg}, 12'd0);

        // Relaunch, then hold fire through flight and cooldown.
        ship_xpos = 11'd50; ship_ypos = 11'd100;
        fire = 1'b1;
        cycle();
        chk("relaunch_pulse", {11'd0, launch},  12'd1);
        chk("relaunch_ypos",  {1'b0, ypos_out}, 12'd80);
        launches_before = n_launch;
        frame_ticks(11);                     // 80 -> 0 in 10 ticks, 11th retires
        chk("held_retired_on", {11'd0, on}, 12'd0);
        frame_ticks(COOL + 3);
        chk("held_no_refire", 12'(n_launch - launches_before), 12'd0);
        chk("held_idle_state", {10'd0, state_dbg}, 12'd0);
        fire = 1'b0;
        cycle();
        ship_xpos = 11'd700; ship_ypos = 11'd320;
        fire = 1'b1;
        cycle();
        chk("rearm_pulse", {11'd0, launch},  12'd1);
        chk("rearm_ypos",  {1'b0, ypos_out}, 12'd300);
        fire = 1'b0;
        cycle();

        // Hit in the same cycle as a tick at ypos 300.
        vsync_in = 1'b1; hit = 1'b1;
        cycle();
        chk("hit_on",    {11'd0, on},        12'd0);
        chk("hit_ypos",  {1'b0, ypos_out},   12'd300);
        chk("hit_state", {10'd0, state_dbg}, 12'd2);
        vsync_in = 1'b0;
        cycle();
        hit = 1'b0;
        frame_ticks(COOL);
        cycle();

        // Edge launch close to the top of the screen.
        ship_xpos = 11'd2047; ship_ypos = 11'd10;
        fire = 1'b1;
        cycle();
        chk("edge_on",   {11'd0, on},      12'd1);
        chk("edge_ypos", {1'b0, ypos_out}, 12'd0);
        chk("edge_xpos", {1'b0, xpos_out}, 12'd2047);
        fire = 1'b0;
        frame_tick();
        chk("edge_retire_on", {11'd0, on}, 12'd0);
        frame_ticks(COOL);
        cycle();

        // Asynchronous reset while flying.
        ship_xpos = 11'd333; ship_ypos = 11'd444;
        fire = 1'b1;
        cycle();
        fire = 1'b0;
        frame_ticks(2);
        chk("prereset_on", {11'd0, on}, 12'd1);
        rst = 1'b1;
        #1;
        chk("async_on",     {11'd0, on},      12'd0);
        chk("async_launch", {11'd0, launch},  12'd0);
        chk("async_xpos",   {1'b0, xpos_out}, 12'd0);
        chk("async_ypos",   {1'b0, ypos_out}, 12'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        fire = 1'b1;
        cycle();
        chk("post_reset_launch", {11'd0, launch}, 12'd1);
        chk("post_reset_ypos",   {1'b0, ypos_out}, 12'd424);
        fire = 1'b0;
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            vsync_in  = ($urandom_range(0, 3) == 0);
            fire      = ($urandom_range(0, 2) != 0);
            hit       = ($urandom_range(0, 40) == 0);
            ship_xpos = 11'($urandom_range(0, 2047));
            ship_ypos = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 30))
                                                    : 11'($urandom_range(0, 2047));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/missile_ctl.md
Name: missile_ctl

Overview:
Player-missile controller that generates the xpos/ypos/on triple consumed by the missile draw stage. It launches a missile from the ship on a fire request and moves it upward once per frame. It retires the missile at the screen top or on a hit, then enforces a cooldown before the next launch. Frame timing is derived from the same vsync that runs alongside the draw pipeline.

Parameters:
SPEED, 8, pixels the missile rises per frame tick
Y_TOP, 0, topmost allowed missile ypos (screen row)
MISSILE_H, 20, missile height; the launch ypos is placed this far above ship_ypos
COOLDOWN_FRAMES, 10, frame ticks spent in COOLDOWN after a missile retires

Ports:
pclk  input  1  pixel clock, single clock domain
rst  input  1  reset, asynchronous, active-high
vsync_in  input  1  vertical sync from the VGA timing chain
fire  input  1  fire request, level, already synchronised/debounced
hit  input  1  collision report for the current missile, level
ship_xpos  input  11  ship left x
ship_ypos  input  11  ship top y
xpos_out  output  11  missile x, registered
ypos_out  output  11  missile y, registered
on  output  1  missile visible/active, registered
launch  output  1  one-cycle pulse on launch (sound/score hooks)

Behaviour:
- Reset (async, rst=1): state=IDLE; xpos_out=0, ypos_out=0, on=0, launch=0; cooldown counter=0; vsync_d=0; fire_armed=1.
- Frame tick: tick = vsync_in & ~vsync_d, with vsync_d registered each cycle. One tick occurs per rising vsync edge.
- fire_armed: cleared on launch; set in any cycle with fire=0. A held button therefore never auto-refires.
- States:
  - IDLE: on=0. If fire & fire_armed, then next cycle:
    - state=FLYING, on=1, launch=1 for one cycle
    - xpos_out=ship_xpos (the draw stage applies the centring offset)
    - ypos_out=ship_ypos-MISSILE_H, saturating at 0 if ship_ypos<MISSILE_H
    - Launch latency is 1 clock from sampled fire.
  - FLYING: evaluated in priority order each cycle:
    1. hit=1 -> on=0, state=COOLDOWN, counter=COOLDOWN_FRAMES. This applies even if a tick occurs in the same cycle.
    2. tick and ypos_out < Y_TOP+SPEED -> on=0, state=COOLDOWN, counter=COOLDOWN_FRAMES.
    3. tick -> ypos_out -= SPEED. xpos_out is held; later ship movement does not steer the missile.
    - fire is ignored while FLYING.
  - COOLDOWN: on=0. Each tick decrements the counter. When counter==0 (checked every cycle), state goes to IDLE next cycle. With COOLDOWN_FRAMES=0, COOLDOWN lasts exactly 1 cycle.
- xpos_out and ypos_out keep their last values while on=0; downstream qualifies the position with on.
- Arithmetic: 11-bit unsigned. The comparison Y_TOP+SPEED is done at 12 bits so no wrap is possible. Subtraction is performed only when the comparison guarantees no underflow.
- launch is 0 in every cycle other than the launch cycle.
- hit outside FLYING is ignored.
- rst asserted mid-flight immediately clears on and returns the block to IDLE with fire_armed=1.

Test Plan:
- Launch: ship_xpos=400, ship_ypos=550, pulse fire in IDLE -> 1 cycle later on=1, xpos_out=400, ypos_out=530, launch high for exactly 1 cycle.
- Flight/top: after the launch above, with no hit -> ypos_out=522 after tick 1 and 2 after tick 66. Tick 67 clears on. After 10 more ticks the state is IDLE; a fire then launches again.
- Held fire: keep fire=1 through flight and cooldown -> no second launch. Drop fire for 1 cycle, re-raise it -> launch next cycle.
- Hit priority: assert hit in the same cycle as a tick while FLYING at ypos_out=300 -> on=0 next cycle, ypos_out stays 300, COOLDOWN entered, no decrement applied.
- Edge launch: ship_ypos=10 -> ypos_out=0 (saturated) and on=1. The first tick clears on.
- Reset mid-flight: assert rst asynchronously while on=1 -> on, launch, xpos_out and ypos_out read 0 before the next pclk edge. After release, fire launches with no cooldown wait.
